result_arbiter: RTL

- Sits directly downstream of the ALU/BU/FPU/memory/UART reservation stations.
- Buffers each unit's result in a small per-source FIFO and picks one result per cycle with round-robin arbitration.
- Broadcasts the winner as the completion message. The RS operand-wakeup logic and the commit stage consume it.
- Decouples the functional units: a unit is back-pressured only when its own FIFO is full.

---
 rtl/result_arbiter_pkg.sv | 44 ++++
 rtl/result_arbiter_fifo.sv | 56 +++++
 rtl/result_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/result_arbiter_pkg.sv
`default_nettype none
// result_arbiter_pkg: packed completion-message layout and source indices.
package result_arbiter_pkg;

   localparam int COMMIT_ID_W = 8;
   localparam int KIND_W      = 1;
   localparam int PHYS_W      = 8;
   localparam int LOGIC_W     = 5;
   localparam int DATA_W      = 32;
   localparam int RESULT_W    = COMMIT_ID_W + KIND_W + PHYS_W + LOGIC_W + DATA_W;

   localparam int SRC_ALU  = 0;
   localparam int SRC_BU   = 1;
   localparam int SRC_FPU  = 2;
   localparam int SRC_MEM  = 3;
   localparam int SRC_UART = 4;
   localparam int N_SRC_DEFAULT = 5;

   typedef struct packed {
      logic [COMMIT_ID_W-1:0] commit_id;
      logic [KIND_W-1:0]      kind;
      logic [PHYS_W-1:0]      dest_phys;
      logic [LOGIC_W-1:0]     dest_logic;
      logic [DATA_W-1:0]      data;
   } result_t;

   function automatic logic [RESULT_W-1:0] pack_result(
      input logic [COMMIT_ID_W-1:0] commit_id,
      input logic [KIND_W-1:0]      kind,
      input logic [PHYS_W-1:0]      dest_phys,
      input logic [LOGIC_W-1:0]     dest_logic,
      input logic [DATA_W-1:0]      data
   );
      result_t r;
      r.commit_id  = commit_id;
      r.kind       = kind;
      r.dest_phys  = dest_phys;
      r.dest_logic = dest_logic;
      r.data       = data;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/result_arbiter_fifo.sv
`default_nettype none
// small_fifo: power-of-two depth FIFO with registered full/empty/count and a flush.
module small_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 54,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flash,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // full comes from the registered count only, so a pop cannot make room for a same-cycle push
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flash & ~reset;
   assign do_pop  = pop & ~empty & ~flash & ~reset;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset || flash) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/result_arbiter.sv
`default_nettype none
// result_arbiter: per-source result FIFOs merged onto one completion bus by round-robin.
module result_arbiter
   import result_arbiter_pkg::*;
#(
   parameter int N_SRC    = 5,
   parameter int DEPTH    = 2,
   parameter int RESULT_W = result_arbiter_pkg::RESULT_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flash,
   input  logic [N_SRC-1:0]          in_en,
   input  logic [N_SRC*RESULT_W-1:0] in_msg,
   output logic [N_SRC-1:0]          in_reject,
   output logic                      out_en,
   output logic [RESULT_W-1:0]       out_msg,
   input  logic                      out_reject
);

   localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [N_SRC-1:0]    full;
   logic [N_SRC-1:0]    empty;
   logic [N_SRC-1:0]    push;
   logic [N_SRC-1:0]    pop;
   logic [N_SRC-1:0]    req;
   logic [N_SRC-1:0]    rot;
   logic [CNT_W-1:0]    count [N_SRC];
   logic [RESULT_W-1:0] head  [N_SRC];
   logic [RR_W-1:0]     rr;
   logic [RR_W-1:0]     first;
   logic [RR_W-1:0]     grant;
   logic                any_valid;

   function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_SRC) s = s - N_SRC;
      return RR_W'(s);
   endfunction

   generate
      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         assign push[i] = in_en[i] & ~full[i];
         assign pop[i]  = out_en & ~out_reject & (grant == RR_W'(i));
         assign req[i]  = ~empty[i];

         small_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (RESULT_W),
            .CNT_W (CNT_W)
         ) u_fifo (
            .clock (clock),
            .reset (reset),
            .flash (flash),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_msg[i*RESULT_W +: RESULT_W]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
         );
      end
   endgenerate

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (count[i] != '0) any_valid = 1'b1;
      end
   end

   // Rotate requests so rr sits at bit 0, pick the lowest set bit, then rotate the index back.
   always_comb begin
      rot = '0;
      for (int k = 0; k < N_SRC; k++) begin
         rot[k] = req[wrap_add(rr, k)];
      end
      first = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (rot[k]) first = RR_W'(k);
      end
      grant = wrap_add(rr, int'(first));
   end

   assign in_reject = full;
   assign out_en    = any_valid & ~flash & ~reset;
   assign out_msg   = head[grant];

   always_ff @(posedge clock) begin
      if (reset || flash) begin
         rr <= '0;
      end else if (out_en && !out_reject) begin
         rr <= (grant == RR_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
      end
   end

endmodule
`default_nettype wire
